// File: rtl/me_pkg.sv
// Shared types for the sub-pixel absolute-difference front end.
package me_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned LANES = 8;
  localparam int unsigned ROW_W = PIX_W * LANES;

  // One row of LANES pixels; lane k sits at [k*PIX_W +: PIX_W].
  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    PRIME0,
    PRIME1,
    RUN
  } state_e;

endpackage

// File: rtl/line_window_feeder_if.sv
// Reference/original input streams and the window output stream of line_window_feeder.
interface line_window_feeder_if;

  logic          cur_valid;
  logic          cur_ready;
  me_pkg::row_t  cur_pix;

  logic          org_valid;
  logic          org_ready;
  me_pkg::row_t  org_pix_in;

  logic          out_valid;
  logic          out_ready;
  me_pkg::row_t  cur_upper_pix;
  me_pkg::row_t  cur_middle_pix;
  me_pkg::row_t  cur_lower_pix;
  me_pkg::row_t  org_pix;
  logic          out_first;
  logic          out_last;

  // Producer/consumer side (frame reader and abs_diff_line)
  modport master (
    output cur_valid, cur_pix, org_valid, org_pix_in, out_ready,
    input  cur_ready, org_ready, out_valid, cur_upper_pix, cur_middle_pix, cur_lower_pix,
    input  org_pix, out_first, out_last
  );

  // Feeder side
  modport slave (
    input  cur_valid, cur_pix, org_valid, org_pix_in, out_ready,
    output cur_ready, org_ready, out_valid, cur_upper_pix, cur_middle_pix, cur_lower_pix,
    output org_pix, out_first, out_last
  );

endinterface

// File: rtl/line_window_feeder.sv
// Sliding three-row reference window paired with the aligned original row, one registered
// beat per original row. Each block re-primes with two fresh reference rows.
module line_window_feeder
  import me_pkg::*;
#(
  parameter int unsigned BLK_ROWS = 8
) (
  input logic                 clk,
  input logic                 rst,
  line_window_feeder_if.slave bus_io
);

  localparam int unsigned CntW = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
  localparam logic [CntW-1:0] LastRow = CntW'(BLK_ROWS - 1);

  state_e          state_q;
  logic [CntW-1:0] row_cnt_q;
  row_t            mid_q, low_q;
  row_t            upper_q, middle_q, lower_q, org_q;
  logic            out_valid_q, out_first_q, out_last_q;

  logic slot_free;
  logic cur_rdy, org_rdy;
  logic run_hs;

  // Ready decode: priming takes reference rows alone, RUN takes both streams together only.
  always_comb begin
    slot_free = !out_valid_q || bus_io.out_ready;
    cur_rdy   = 1'b0;
    org_rdy   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        PRIME0, PRIME1: cur_rdy = 1'b1;
        RUN: begin
          cur_rdy = slot_free && bus_io.cur_valid && bus_io.org_valid;
          org_rdy = cur_rdy;
        end
        default: ;
      endcase
    end
  end

  // org_rdy is only ever high on a joint handshake in RUN
  assign run_hs = org_rdy;

  // FSM, window shift and output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PRIME0;
      row_cnt_q   <= '0;
      mid_q       <= '0;
      low_q       <= '0;
      upper_q     <= '0;
      middle_q    <= '0;
      lower_q     <= '0;
      org_q       <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        PRIME0: begin
          if (bus_io.cur_valid) begin
            mid_q   <= bus_io.cur_pix;
            state_q <= PRIME1;
          end
        end
        PRIME1: begin
          if (bus_io.cur_valid) begin
            low_q   <= bus_io.cur_pix;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (run_hs) begin
            mid_q <= low_q;
            low_q <= bus_io.cur_pix;
            if (row_cnt_q == LastRow) begin
              row_cnt_q <= '0;
              state_q   <= PRIME0;
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= PRIME0;
      endcase

      // A pending beat drains on out_ready even while the next block is priming.
      if (run_hs) begin
        upper_q     <= mid_q;
        middle_q    <= low_q;
        lower_q     <= bus_io.cur_pix;
        org_q       <= bus_io.org_pix_in;
        out_valid_q <= 1'b1;
        out_first_q <= (row_cnt_q == '0);
        out_last_q  <= (row_cnt_q == LastRow);
      end else if (bus_io.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus_io.cur_ready      = cur_rdy;
  assign bus_io.org_ready      = org_rdy;
  assign bus_io.out_valid      = out_valid_q;
  assign bus_io.cur_upper_pix  = upper_q;
  assign bus_io.cur_middle_pix = middle_q;
  assign bus_io.cur_lower_pix  = lower_q;
  assign bus_io.org_pix        = org_q;
  assign bus_io.out_first      = out_first_q;
  assign bus_io.out_last       = out_last_q;

endmodule
